// File: rtl/ternary_stream_loader.sv
// Stream-fed program loader for balanced-ternary instruction memory.
// Writes streamed words to consecutive addresses, or re-reads and counts mismatches in VERIFY mode.
module ternary_stream_loader #(
  parameter int unsigned WORD_SIZE     = 9,
  parameter int unsigned MEM_ADDR_SIZE = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [2*MEM_ADDR_SIZE-1:0]   base_addr,
  input  logic [CNT_W-1:0]             word_count,
  input  logic                         abort,
  input  logic                         s_valid,
  input  logic [2*WORD_SIZE-1:0]       s_data,
  output logic                         s_ready,
  output logic [2*MEM_ADDR_SIZE-1:0]   mem_addr,
  output logic [2*WORD_SIZE-1:0]       mem_write_data,
  output logic                         mem_write,
  output logic                         mem_read,
  input  logic [2*WORD_SIZE-1:0]       mem_read_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   error_code,
  output logic [CNT_W-1:0]             mismatch_count,
  output logic [2*MEM_ADDR_SIZE-1:0]   first_mismatch_addr
);

  localparam int unsigned AW = 2 * MEM_ADDR_SIZE;
  localparam int unsigned DW = 2 * WORD_SIZE;

  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  localparam logic [AW-1:0] ADDR_MIN  = {MEM_ADDR_SIZE{TRIT_NEG}};
  localparam logic [AW-1:0] ADDR_MAX  = {MEM_ADDR_SIZE{TRIT_POS}};
  localparam logic [AW-1:0] ADDR_ZERO = {MEM_ADDR_SIZE{TRIT_ZERO}};
  localparam logic [DW-1:0] WORD_ZERO = {WORD_SIZE{TRIT_ZERO}};

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TRIT  = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_READ,
    ST_COMPARE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [DW-1:0]     word_q, word_n;
  logic [CNT_W-1:0]  remain_q, remain_n;
  logic              verify_q, verify_n;
  logic [1:0]        code_q, code_n;
  logic [CNT_W-1:0]  mcount_q, mcount_n;
  logic [AW-1:0]     first_q, first_n;
  logic              active;

  // Balanced-ternary +1: a +1 trit wraps to -1 and carries; the top carry is dropped.
  function automatic logic [AW-1:0] bt_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic          c;
    r = a;
    c = 1'b1;
    for (int unsigned i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (c) begin
        case (a[2*i +: 2])
          TRIT_NEG:  begin r[2*i +: 2] = TRIT_ZERO; c = 1'b0; end
          TRIT_ZERO: begin r[2*i +: 2] = TRIT_POS;  c = 1'b0; end
          TRIT_POS:  begin r[2*i +: 2] = TRIT_NEG;  c = 1'b1; end
          default:   c = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic has_bad_trit(input logic [DW-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      if (w[2*i +: 2] == TRIT_BAD) bad = 1'b1;
    end
    return bad;
  endfunction

  assign active = (state == ST_FETCH) || (state == ST_WRITE) ||
                  (state == ST_READ)  || (state == ST_COMPARE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr_q   <= ADDR_MIN;
      word_q   <= WORD_ZERO;
      remain_q <= '0;
      verify_q <= 1'b0;
      code_q   <= ERR_NONE;
      mcount_q <= '0;
      first_q  <= ADDR_ZERO;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      word_q   <= word_n;
      remain_q <= remain_n;
      verify_q <= verify_n;
      code_q   <= code_n;
      mcount_q <= mcount_n;
      first_q  <= first_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    word_n   = word_q;
    remain_n = remain_q;
    verify_n = verify_q;
    code_n   = code_q;
    mcount_n = mcount_q;
    first_n  = first_q;

    if (active && abort) begin
      state_n = ST_ERROR;
      code_n  = ERR_ABORT;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            verify_n = mode;
            addr_n   = base_addr;
            remain_n = word_count;
            code_n   = ERR_NONE;
            mcount_n = '0;
            first_n  = ADDR_ZERO;
            state_n  = (word_count == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (s_valid) begin
            if (has_bad_trit(s_data)) begin
              state_n = ST_ERROR;
              code_n  = ERR_TRIT;
            end else begin
              word_n  = s_data;
              state_n = verify_q ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_READ: begin
          remain_n = remain_q - CNT_W'(1);
          state_n  = ST_COMPARE;
        end
        ST_WRITE, ST_COMPARE: begin
          // WRITE decrements here; VERIFY already decremented in READ, so both
          // paths reach the shared advance logic with the post-word remainder.
          if (state == ST_WRITE) begin
            remain_n = remain_q - CNT_W'(1);
          end else if (mem_read_data != word_q) begin
            if (mcount_q != '1) mcount_n = mcount_q + CNT_W'(1);
            if (mcount_q == '0) first_n = addr_q;
          end
          if (remain_n == '0) begin
            state_n = ST_DONE;
          end else if (addr_q == ADDR_MAX) begin
            state_n = ST_ERROR;
            code_n  = ERR_OVF;
          end else begin
            addr_n  = bt_inc(addr_q);
            state_n = ST_FETCH;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign s_ready             = (state == ST_FETCH);
  assign mem_write           = (state == ST_WRITE);
  assign mem_read            = (state == ST_READ);
  assign busy                = active;
  assign done                = (state == ST_DONE);
  assign error               = (state == ST_ERROR);
  assign mem_addr            = addr_q;
  assign mem_write_data      = word_q;
  assign error_code          = code_q;
  assign mismatch_count      = mcount_q;
  assign first_mismatch_addr = first_q;

endmodule

// File: tb/tb_ternary_stream_loader.sv
// Bench for ternary_stream_loader: random words, memory model indexed by integer address.
module tb_ternary_stream_loader;

  localparam int unsigned WS = 9;
  localparam int unsigned AS = 2;
  localparam int unsigned CW = 16;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic            abort = 1'b0;
  logic            s_valid = 1'b0;
  logic [2*AS-1:0] base_addr = '0;
  logic [CW-1:0]   word_count = '0;
  logic [2*WS-1:0] s_data = '0;
  logic [2*WS-1:0] mem_read_data = '0;
  logic            s_ready, mem_write, mem_read, busy, done, error;
  logic [2*AS-1:0] mem_addr, first_mismatch_addr;
  logic [2*WS-1:0] mem_write_data;
  logic [1:0]      error_code;
  logic [CW-1:0]   mismatch_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int ready_bad = 0;
  logic [2*WS-1:0] mem [int];
  int              wr_addr [$];
  logic [2*WS-1:0] wr_data [$];
  int              wr_cyc  [$];

  ternary_stream_loader #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .word_count(word_count), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .mismatch_count(mismatch_count), .first_mismatch_addr(first_mismatch_addr)
  );

  always #5 clock = ~clock;

  function automatic int from_bt(input logic [2*AS-1:0] a);
    int v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < int'(AS); i++) begin
      if (a[2*i +: 2] == T_POS) v += p;
      else if (a[2*i +: 2] == T_NEG) v -= p;
      p *= 3;
    end
    return v;
  endfunction

  function automatic logic [2*AS-1:0] to_bt(input int val);
    logic [2*AS-1:0] a;
    int v, r;
    v = val;
    a = '0;
    for (int i = 0; i < int'(AS); i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 0) begin a[2*i +: 2] = T_ZERO; v = v / 3; end
      else if (r == 1) begin a[2*i +: 2] = T_POS; v = (v - 1) / 3; end
      else begin a[2*i +: 2] = T_NEG; v = (v + 1) / 3; end
    end
    return a;
  endfunction

  function automatic logic [2*WS-1:0] rand_word();
    logic [2*WS-1:0] w;
    int r;
    w = '0;
    for (int i = 0; i < int'(WS); i++) begin
      r = int'($urandom_range(0, 2));
      w[2*i +: 2] = (r == 0) ? T_NEG : (r == 1) ? T_ZERO : T_POS;
    end
    return w;
  endfunction

  function automatic logic [2*WS-1:0] corrupt(input logic [2*WS-1:0] w);
    logic [2*WS-1:0] c;
    c = w;
    c[1:0] = (w[1:0] == T_POS) ? T_NEG : T_POS;
    return c;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (mem_write) begin
      wr_addr.push_back(from_bt(mem_addr));
      wr_data.push_back(mem_write_data);
      wr_cyc.push_back(cyc);
      mem[from_bt(mem_addr)] = mem_write_data;
    end
    if (mem_read) begin
      rd_cnt++;
      mem_read_data <= mem.exists(from_bt(mem_addr)) ? mem[from_bt(mem_addr)] : '0;
    end
    if (s_ready && (mem_write || mem_read || !busy)) ready_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic start_op(input logic m, input int base, input int cnt);
    mode = m;
    base_addr = to_bt(base);
    word_count = CW'(cnt);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [2*WS-1:0] w, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge clock);
    s_valid = 1'b1;
    s_data = w;
    t = 0;
    while (!s_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20) begin
      chk("push_timeout", 64'(t), 64'(0));
    end else begin
      @(negedge clock);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk({tag, "_timeout"}, 64'(t < 50), 64'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {s_ready, mem_write, mem_read, busy, done, error, error_code}, '0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'({T_NEG, T_NEG}));
    chk({tag, "_wdata"}, 64'(mem_write_data), '0);
    chk({tag, "_mcount"}, 64'(mismatch_count), '0);
    chk({tag, "_first"}, 64'(first_mismatch_addr), '0);
  endtask

  initial begin
    logic [2*WS-1:0] w [8];
    logic [2*WS-1:0] bad;
    int cnt, base, gap, mask, exp_mm, exp_first;

    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clock);

    // LOAD, continuous stream: -4, -3, -2, two cycles apart
    clear_log();
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    start_op(1'b0, -4, 3);
    chk("start_to_ready", 64'({s_ready, busy}), 64'(2'b11));
    for (int i = 0; i < 3; i++) push_word(w[i], 0);
    wait_end("load1");
    chk("load1_nwr", 64'(wr_addr.size()), 64'(3));
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      chk("load1_addr", 64'(wr_addr[i]), 64'(-4 + i));
      chk("load1_data", 64'(wr_data[i]), 64'(w[i]));
      if (i > 0) chk("load1_spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'(2));
    end
    chk("load1_status", 64'({done, error, busy}), 64'(3'b100));

    // LOAD with random stream gaps and random base
    for (int trial = 0; trial < 3; trial++) begin
      clear_log();
      cnt  = int'($urandom_range(1, 5));
      base = int'($urandom_range(0, 9 - cnt)) - 4;
      for (int i = 0; i < cnt; i++) w[i] = rand_word();
      start_op(1'b0, base, cnt);
      for (int i = 0; i < cnt; i++) begin
        gap = int'($urandom_range(0, 3));
        push_word(w[i], gap);
      end
      wait_end("load2");
      chk("load2_nwr", 64'(wr_addr.size()), 64'(cnt));
      for (int i = 0; i < cnt && i < wr_addr.size(); i++) begin
        chk("load2_addr", 64'(wr_addr[i]), 64'(base + i));
        chk("load2_data", 64'(wr_data[i]), 64'(w[i]));
      end
      chk("load2_done", 64'({done, error}), 64'(2'b10));
    end
    chk("ready_outside_fetch", 64'(ready_bad), 64'(0));

    // Address overflow at +4
    clear_log();
    w[0] = rand_word();
    start_op(1'b0, 4, 2);
    push_word(w[0], 0);
    wait_end("ovf");
    chk("ovf_status", 64'({done, error, error_code}), 64'(4'b0110));
    chk("ovf_nwr", 64'(wr_addr.size()), 64'(1));
    if (wr_addr.size() > 0) chk("ovf_addr", 64'(wr_addr[0]), 64'(4));

    // Illegal trit in second word
    clear_log();
    w[0] = rand_word();
    bad = rand_word();
    bad[9:8] = 2'b11;
    start_op(1'b0, 0, 3);
    chk("restart_clears_code", 64'({error, error_code}), 64'(0));
    push_word(w[0], 0);
    push_word(bad, 1);
    wait_end("trit");
    chk("trit_status", 64'({done, error, error_code}), 64'(4'b0101));
    chk("trit_nwr", 64'(wr_addr.size()), 64'(1));
    if (wr_addr.size() > 0) chk("trit_data", 64'(wr_data[0]), 64'(w[0]));
    chk("trit_mcount", 64'(mismatch_count), 64'(0));

    // LOAD 4 words, corrupt base+2, VERIFY
    base = int'($urandom_range(0, 5)) - 4;
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    clear_log();
    start_op(1'b0, base, 4);
    for (int i = 0; i < 4; i++) push_word(w[i], 0);
    wait_end("vload");
    chk("vload_nwr", 64'(wr_addr.size()), 64'(4));
    mem[base + 2] = corrupt(w[2]);
    clear_log();
    start_op(1'b1, base, 4);
    for (int i = 0; i < 4; i++) push_word(w[i], 0);
    wait_end("verify1");
    chk("verify1_mcount", 64'(mismatch_count), 64'(1));
    chk("verify1_first", 64'(first_mismatch_addr), 64'(to_bt(base + 2)));
    chk("verify1_status", 64'({done, error}), 64'(2'b10));
    chk("verify1_nwr", 64'(wr_addr.size()), 64'(0));
    chk("verify1_nrd", 64'(rd_cnt), 64'(4));

    // VERIFY with a random set of corrupted addresses
    for (int trial = 0; trial < 2; trial++) begin
      mask = int'($urandom_range(0, 15));
      exp_mm = 0;
      exp_first = -1;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          mem[base + i] = corrupt(w[i]);
          exp_mm++;
          if (exp_first < 0) exp_first = i;
        end else begin
          mem[base + i] = w[i];
        end
      end
      clear_log();
      start_op(1'b1, base, 4);
      chk("verify2_cleared", 64'(mismatch_count), 64'(0));
      for (int i = 0; i < 4; i++) push_word(w[i], int'($urandom_range(0, 2)));
      wait_end("verify2");
      chk("verify2_mcount", 64'(mismatch_count), 64'(exp_mm));
      chk("verify2_first", 64'(first_mismatch_addr),
          64'((exp_first < 0) ? '0 : to_bt(base + exp_first)));
      chk("verify2_done", 64'(done), 64'(1));
    end

    // Reset asserted while in WRITE
    w[0] = rand_word();
    start_op(1'b0, -4, 2);
    push_word(w[0], 0);
    chk("rst_in_write", 64'(mem_write), 64'(1));
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("rst_mid");
    reset = 1'b1;
    @(negedge clock);

    // Abort in FETCH
    clear_log();
    start_op(1'b0, 0, 2);
    chk("abort_in_fetch", 64'(s_ready), 64'(1));
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_status", 64'({done, error, error_code, busy}), 64'(5'b01110));
    chk("abort_nwr", 64'(wr_addr.size()), 64'(0));

    // Zero word count: done one cycle after start, no strobes
    clear_log();
    start_op(1'b0, 1, 0);
    chk("zero_status", 64'({done, error, error_code, busy, s_ready}), 64'(6'b100000));
    chk("zero_addr", 64'(mem_addr), 64'(to_bt(1)));
    @(negedge clock);
    chk("zero_strobes", 64'(wr_addr.size() + rd_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ternary_stream_loader.md
# ternary_stream_loader

Parametrised, synthesisable program loader for the ternary processor memory. Accepts instruction words over a valid/ready stream instead of file I/O. Writes them to consecutive balanced-ternary addresses starting from a programmable base. Optionally re-reads memory in a verify pass and counts mismatches. Sits between the host/boot stream and the instruction memory write port, ahead of processor start.

## Interface
Trit codes come from `parameters.vh`: `_1` = −1, `_0` = 0, `_1_` = +1. Each trit is 2 bits; the fourth 2-bit pattern is illegal.

Parameters:
- WORD_SIZE, 9: trits per memory word.
- MEM_ADDR_SIZE, 4: trits per address; range −(3^N−1)/2 … +(3^N−1)/2.
- CNT_W, 16: binary width of the word counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clock edge).
- start  in  1  begin an operation; sampled only in IDLE, DONE or ERROR.
- mode  in  1  0 = LOAD, 1 = VERIFY; captured on start.
- base_addr  in  2*MEM_ADDR_SIZE  first address; captured on start.
- word_count  in  CNT_W  number of words (binary); captured on start.
- abort  in  1  terminate the current operation.
- s_valid  in  1  stream word valid.
- s_data  in  2*WORD_SIZE  stream word.
- s_ready  out  1  loader can accept s_data.
- mem_addr  out  2*MEM_ADDR_SIZE  memory address.
- mem_write_data  out  2*WORD_SIZE  memory write data.
- mem_write  out  1  write strobe, one cycle per word.
- mem_read  out  1  read strobe (VERIFY only).
- mem_read_data  in  2*WORD_SIZE  read data, valid the cycle after mem_read.
- busy  out  1  operation in progress.
- done  out  1  level; operation finished with no error.
- error  out  1  level; operation terminated.
- error_code  out  2  01 illegal trit, 10 address overflow, 11 abort.
- mismatch_count  out  CNT_W  VERIFY mismatches.
- first_mismatch_addr  out  2*MEM_ADDR_SIZE  address of the first mismatch.

## Operation
- States: IDLE, FETCH, WRITE, READ, COMPARE, DONE, ERROR.
- IDLE/DONE/ERROR with start=1:
  - Capture mode, base_addr and word_count.
  - Load mem_addr ← base_addr; clear done, error, error_code, mismatch_count and first_mismatch_addr.
  - word_count = 0 → DONE; otherwise → FETCH.
- FETCH:
  - s_ready = 1.
  - On s_valid & s_ready, check every trit of s_data.
  - Any illegal pattern → ERROR, code 01, nothing written.
  - Otherwise latch the word and go to WRITE (LOAD) or READ (VERIFY).
- WRITE: mem_write = 1 with mem_addr and mem_write_data; decrement the remaining count.
- READ: mem_read = 1; decrement the remaining count.
- COMPARE:
  - mem_read_data ≠ latched word → increment mismatch_count (saturating).
  - On the first mismatch, also capture first_mismatch_addr.
  - VERIFY never errors on a mismatch.
- After WRITE or COMPARE:
  - Remaining = 0 → DONE.
  - Remaining > 0 and mem_addr = all `_1_` (max) → ERROR, code 10.
  - Otherwise mem_addr ← mem_addr + 1, using a balanced-ternary ripple increment truncated to MEM_ADDR_SIZE, then → FETCH.
- abort=1 in FETCH/WRITE/READ/COMPARE → ERROR, code 11, taking priority over all other transitions. A strobe already driven that cycle completes.
- DONE and ERROR hold until start or reset.

## Timing
- Reset (reset=0 at an edge), effective at that edge from any state:
  - State → IDLE.
  - mem_addr = all `_1` (minimum).
  - mem_write_data, mismatch_count and first_mismatch_addr = all `_0` / 0.
  - s_ready, mem_write, mem_read, busy, done, error = 0; error_code = 00.
- busy = 1 in FETCH, WRITE, READ and COMPARE.
- LOAD throughput: 1 word per 2 cycles. Handshake at edge n; mem_write high during cycle n+1.
- VERIFY throughput: 1 word per 3 cycles. Handshake n, mem_read in n+1, compare in n+2.
- s_ready is low outside FETCH, so no word is accepted during WRITE, READ or COMPARE.
- done/error assert the cycle after the last strobe or the terminating condition.
- Start→first s_ready: 1 cycle.

## Test plan
- LOAD, MEM_ADDR_SIZE=2, base = `_1``_1` (−4), count 3, words A,B,C with s_valid always high → writes at −4, −3, −2; mem_write exactly 3 one-cycle pulses, 2 cycles apart; done=1.
- LOAD with s_valid gaps (random 0–3 idle cycles) → identical memory contents and ordering; s_ready never high outside FETCH.
- Overflow: base = `_1_``_1_` (+4), count 2 → one write at +4; then error=1, code 10; no second write.
- Illegal trit in the second word → first word written; error code 01; second not written; mismatch_count 0.
- VERIFY of 4 words after LOAD, with memory model corrupted at the address base+2 → mismatch_count 1; first_mismatch_addr = base+2; done=1.
- Mid-operation events:
  - reset=0 during WRITE → next cycle all outputs at reset values.
  - abort during FETCH → error code 11.
  - word_count 0 → done one cycle after start, with no strobes.
